// File: rtl/tinker_arb_pkg.sv
// Shared state encoding and constants for the Tinker fetch/data storage arbiter.
package tinker_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    ERR
  } arb_state_t;

  localparam logic       OWN_FETCH   = 1'b0;
  localparam logic       OWN_DATA    = 1'b1;
  localparam logic [1:0] FETCH_ALIGN = 2'b11;
  localparam logic [2:0] DATA_ALIGN  = 3'b111;

endpackage

// File: rtl/tinker_rr_arb2.sv
// Two-way round-robin pick between fetch (bit 0) and data (bit 1).
module tinker_rr_arb2
  import tinker_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       sel_owner
);

  always_comb begin
    sel_owner = OWN_FETCH;
    if (req[OWN_FETCH] && req[OWN_DATA]) begin
      // on a tie, whoever was not served last goes next
      sel_owner = (last_grant == OWN_DATA) ? OWN_FETCH : OWN_DATA;
    end else if (req[OWN_DATA]) begin
      sel_owner = OWN_DATA;
    end
    grant = 2'b00;
    if (req != 2'b00) begin
      grant = (sel_owner == OWN_DATA) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Shares the single-port unified storage between instruction fetch and data
// access; one transaction in flight, fixed-latency response pulses.
module tinker_mem_arbiter
  import tinker_arb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 64
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  output logic              if_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [63:0]       d_req_wdata,
  output logic              d_rsp_valid,
  output logic [63:0]       d_rsp_data,
  output logic              d_rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);

  // state | meaning
  // IDLE  | arbitration live, ready may assert
  // ISSUE | single-cycle mem_en for the accepted request
  // WAIT  | down-counting the storage latency
  // RESP  | owner's rsp_valid pulse
  // ERR   | misaligned request rejected, owner's rsp_err pulse

  arb_state_t state, state_next;
  logic [3:0] cnt;
  logic       last_grant;
  logic       owner;
  logic       we_q;
  logic [1:0] grant;
  logic       sel_owner;
  logic       accept;
  logic       misaligned;

  tinker_rr_arb2 u_rr (
    .req       ({d_req_valid, if_req_valid}),
    .last_grant(last_grant),
    .grant     (grant),
    .sel_owner (sel_owner)
  );

  assign if_req_ready = (state == IDLE) && grant[OWN_FETCH];
  assign d_req_ready  = (state == IDLE) && grant[OWN_DATA];
  assign accept       = (if_req_valid && if_req_ready) || (d_req_valid && d_req_ready);
  assign misaligned   = (sel_owner == OWN_DATA) ? |(d_req_addr[2:0] & DATA_ALIGN)
                                                : |(if_req_addr[1:0] & FETCH_ALIGN);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = misaligned ? ERR : ISSUE;
      ISSUE:    state_next = WAIT;
      WAIT:     if (cnt == 4'd0) state_next = RESP;
      RESP:     state_next = IDLE;
      ERR:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= OWN_DATA;
      owner      <= OWN_FETCH;
      we_q       <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        last_grant <= sel_owner;
        owner      <= sel_owner;
        we_q       <= (sel_owner == OWN_DATA) && d_req_we;
      end
      if (state == ISSUE) begin
        cnt <= 4'(MEM_LAT - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      if_rsp_valid <= 1'b0;
      if_rsp_err   <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_err    <= 1'b0;
      d_rsp_data   <= '0;
    end else begin
      mem_en       <= (state_next == ISSUE);
      mem_we       <= (state_next == ISSUE) && (sel_owner == OWN_DATA) && d_req_we;
      busy         <= (state_next != IDLE);
      if_rsp_valid <= 1'b0;
      if_rsp_err   <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_err    <= 1'b0;
      d_rsp_data   <= '0;
      if (state_next == ISSUE) begin
        mem_addr  <= (sel_owner == OWN_DATA) ? d_req_addr : if_req_addr;
        mem_wdata <= (sel_owner == OWN_DATA) ? d_req_wdata : '0;
      end
      // ERR is entered straight from IDLE, so the live selection is the owner
      if (state_next == ERR) begin
        if (sel_owner == OWN_DATA) begin
          d_rsp_valid <= 1'b1;
          d_rsp_err   <= 1'b1;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_err   <= 1'b1;
        end
      end else if (state == WAIT && state_next == RESP) begin
        if (owner == OWN_DATA) begin
          d_rsp_valid <= 1'b1;
          d_rsp_data  <= we_q ? 64'd0 : mem_rdata;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= mem_rdata[31:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Scoreboard bench for tinker_mem_arbiter at MEM_LAT 2, 1 and 15: directed
// test-plan items followed by random traffic against a timestamped model.
module tb_tinker_mem_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        own;
    logic        err;
    logic [63:0] data;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          cyc;
  } acc_t;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected event, expected none (t=%0t)", name, $time);
  endfunction

  // Initial storage contents; 0x2000 holds the fixed test-plan word.
  function automatic logic [63:0] pat(input logic [63:0] a);
    if (a == 64'h2000) return 64'hDEADBEEF_0A0B0C0D;
    return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0] + 32'h77};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    localparam int NCYC = 530;

    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [63:0] if_req_addr;
    logic [31:0] if_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
    logic [63:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic        mem_en, mem_we, busy;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    logic [63:0] mem_store [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];
    logic [63:0] pipe_d [L];
    bit          pipe_v [L];
    logic [63:0] junk;

    rsp_t rq[$];
    acc_t aq[$];
    rsp_t r;
    acc_t ma;
    int   free_cyc;
    logic last_own;
    logic exp_if_rdy, exp_d_rdy, exp_busy, exp_me;
    bit   active = 1'b0;
    bit   done = 1'b0;

    tinker_mem_arbiter #(.MEM_LAT(L), .ADDR_W(64)) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .if_req_valid(if_req_valid),
      .if_req_ready(if_req_ready),
      .if_req_addr (if_req_addr),
      .if_rsp_valid(if_rsp_valid),
      .if_rsp_data (if_rsp_data),
      .if_rsp_err  (if_rsp_err),
      .d_req_valid (d_req_valid),
      .d_req_ready (d_req_ready),
      .d_req_addr  (d_req_addr),
      .d_req_we    (d_req_we),
      .d_req_wdata (d_req_wdata),
      .d_rsp_valid (d_rsp_valid),
      .d_rsp_data  (d_rsp_data),
      .d_rsp_err   (d_rsp_err),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .busy        (busy)
    );

    // Storage: read data is valid exactly L cycles after the mem_en cycle,
    // random junk at every other time.
    always @(posedge clock) begin
      for (int i = L - 1; i > 0; i--) begin
        pipe_d[i] <= pipe_d[i-1];
        pipe_v[i] <= pipe_v[i-1];
      end
      pipe_v[0] <= mem_en && !mem_we;
      pipe_d[0] <= mem_store.exists(mem_addr) ? mem_store[mem_addr] : pat(mem_addr);
      junk      <= {$urandom, $urandom};
    end

    always @(posedge clock) begin
      if (mem_en && mem_we) mem_store[mem_addr] = mem_wdata;
    end

    assign mem_rdata = pipe_v[L-1] ? pipe_d[L-1] : junk;

    // Monitor
    always @(negedge clock) begin
      if (active) begin
        chk($sformatf("L%0d if_req_ready", L), 64'(if_req_ready), 64'(exp_if_rdy));
        chk($sformatf("L%0d d_req_ready", L), 64'(d_req_ready), 64'(exp_d_rdy));
        chk($sformatf("L%0d one_ready", L), 64'(if_req_ready & d_req_ready), 64'd0);
        chk($sformatf("L%0d busy", L), 64'(busy), 64'(exp_busy));

        exp_me = (aq.size() != 0) && (aq[0].cyc == cyc);
        chk($sformatf("L%0d mem_en", L), 64'(mem_en), 64'(exp_me));
        if (exp_me) begin
          ma = aq.pop_front();
          chk($sformatf("L%0d mem_addr", L), mem_addr, ma.addr);
          chk($sformatf("L%0d mem_we", L), 64'(mem_we), 64'(ma.we));
          if (ma.we) chk($sformatf("L%0d mem_wdata", L), mem_wdata, ma.wdata);
        end else if (aq.size() != 0 && aq[0].cyc < cyc) begin
          aq.delete(0);
        end

        if (if_rsp_valid || d_rsp_valid) begin
          chk($sformatf("L%0d both_rsp", L), 64'(if_rsp_valid & d_rsp_valid), 64'd0);
          if (rq.size() == 0) begin
            fail($sformatf("L%0d rsp_unexpected", L));
          end else begin
            r = rq.pop_front();
            chk($sformatf("L%0d rsp_cycle", L), 64'(cyc), 64'(r.cyc));
            chk($sformatf("L%0d rsp_owner", L), 64'(d_rsp_valid), 64'(r.own));
            chk($sformatf("L%0d rsp_err", L), 64'(d_rsp_valid ? d_rsp_err : if_rsp_err), 64'(r.err));
            chk($sformatf("L%0d rsp_data", L), d_rsp_valid ? d_rsp_data : {32'd0, if_rsp_data}, r.data);
          end
        end else begin
          chk($sformatf("L%0d idle_rsp_err", L), 64'(if_rsp_err | d_rsp_err), 64'd0);
          if (rq.size() != 0 && rq[0].cyc < cyc) begin
            fail($sformatf("L%0d rsp_missing", L));
            rq.delete(0);
          end
        end
      end
    end

    // Driver and reference model
    initial begin
      logic        iv, dvv, dwev, own, mis, we, busy_e;
      logic [63:0] ia, dab, dwdv, a, rd;
      rst_n = 1'b0;
      if_req_valid = 1'b0; if_req_addr = '0;
      d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_wdata = '0;
      free_cyc = 0; last_own = 1'b1;
      exp_if_rdy = 1'b0; exp_d_rdy = 1'b0; exp_busy = 1'b0;
      @(negedge clock);
      active = 1'b1;
      @(posedge clock); #1;
      chk($sformatf("L%0d reset_outputs", L),
          {57'd0, mem_en, mem_we, busy, if_rsp_valid, if_rsp_err, d_rsp_valid, d_rsp_err}, 64'd0);
      chk($sformatf("L%0d reset_data", L), d_rsp_data | {32'd0, if_rsp_data} | mem_addr | mem_wdata, 64'd0);
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;

      for (int k = 0; k < NCYC + 20; k++) begin
        @(posedge clock); #1;
        iv = 1'b0; dvv = 1'b0; dwev = 1'b0;
        ia = 64'h1000; dab = 64'h1008; dwdv = 64'd0;
        if (k == 0) begin
          iv = 1'b1; ia = 64'h2000;
        end else if (k == 20) begin
          dvv = 1'b1; dab = 64'h3008; dwev = 1'b1; dwdv = 64'h1122334455667788;
        end else if (k >= 40 && k < 60) begin
          iv = 1'b1; dvv = 1'b1; ia = 64'h1010 + 64'(k % 4) * 4; dab = 64'h1018;
        end else if (k >= 80 && k < 83) begin
          iv = 1'b1; dvv = 1'b1; ia = 64'h2002; dab = 64'h3004;
        end else if (k == 100) begin
          iv = 1'b1; ia = 64'h2000;
        end else if (k >= 105 && k < 115) begin
          iv = 1'b1; dvv = 1'b1; ia = 64'h1020; dab = 64'h3008;
        end else if (k >= 130 && k < NCYC) begin
          iv  = ($urandom % 3) != 0;
          dvv = ($urandom % 3) != 0;
          ia  = 64'h1000 + 64'($urandom_range(0, 7)) * 8 + 64'($urandom_range(0, 1)) * 4;
          if ($urandom % 4 == 0) ia = ia | 64'hFFFF_0000_0000_0000;
          if ($urandom % 8 == 0) ia = ia + 64'($urandom_range(1, 3));
          dab = 64'h1000 + 64'($urandom_range(0, 7)) * 8;
          if ($urandom % 8 == 0) dab = dab + 64'($urandom_range(1, 7));
          dwev = $urandom % 2;
          dwdv = {$urandom, $urandom};
        end
        if_req_valid = iv; if_req_addr = ia;
        d_req_valid = dvv; d_req_addr = dab; d_req_we = dwev; d_req_wdata = dwdv;

        // reset lands in the WAIT of the fetch accepted at k == 100
        if (k == 102) begin
          rst_n = 1'b0;
          #1;
          chk($sformatf("L%0d midreset_outputs", L),
              {57'd0, mem_en, mem_we, busy, if_rsp_valid, if_rsp_err, d_rsp_valid, d_rsp_err}, 64'd0);
          chk($sformatf("L%0d midreset_addr", L), mem_addr, 64'd0);
          rq.delete(); aq.delete();
          free_cyc = 0; last_own = 1'b1;
        end
        if (k == 104) rst_n = 1'b1;

        busy_e = cyc < free_cyc;
        own = (iv && dvv) ? ~last_own : dvv;
        exp_busy   = busy_e;
        exp_if_rdy = !busy_e && iv && !own;
        exp_d_rdy  = !busy_e && dvv && own;
        if (rst_n && (exp_if_rdy || exp_d_rdy)) begin
          a = own ? dab : ia;
          mis = own ? (a[2:0] != 3'd0) : (a[1:0] != 2'd0);
          last_own = own;
          if (mis) begin
            rq.push_back('{own, 1'b1, 64'd0, cyc + 1});
            free_cyc = cyc + 2;
          end else begin
            we = own && dwev;
            aq.push_back('{we, a, dwdv, cyc + 1});
            if (we) begin
              ref_mem[a] = dwdv;
              rd = 64'd0;
            end else begin
              rd = ref_mem.exists(a) ? ref_mem[a] : pat(a);
              if (!own) rd = {32'd0, rd[31:0]};
            end
            rq.push_back('{own, 1'b0, rd, cyc + 2 + L});
            free_cyc = cyc + 3 + L;
          end
        end
      end
      @(negedge clock); #1;
      chk($sformatf("L%0d rsp_left", L), 64'(rq.size()), 64'd0);
      chk($sformatf("L%0d mem_left", L), 64'(aq.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 3000; t++) begin
      @(posedge clock);
      if (gi[0].done && gi[1].done && gi[2].done) break;
    end
    chk("all_done", {61'd0, gi[2].done, gi[1].done, gi[0].done}, 64'd7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
